// File: rtl/rs_issue_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rs_issue_queue : compacting age-ordered reservation station, CDB wakeup
// Rev 1.0
// ---------------------------------------------------------------------------
module rs_issue_queue #(
    parameter int RS_SIZE    = 16,
    parameter int DISPATCH_W = 3,
    parameter int CDB_W      = 3,
    parameter int NUM_PORTS  = 5,
    parameter int TAG_W      = 6,
    parameter int CLS_W      = 3,
    parameter int PAYLOAD_W  = 32,
    parameter logic [NUM_PORTS*CLS_W-1:0] PORT_CLASS = {3'd2, 3'd1, 3'd0, 3'd0, 3'd0}
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            flush_i,
    input  logic [DISPATCH_W-1:0]           dispatch_valid_i,
    input  logic [DISPATCH_W*TAG_W-1:0]     dispatch_t1_i,
    input  logic [DISPATCH_W-1:0]           dispatch_t1_rdy_i,
    input  logic [DISPATCH_W*TAG_W-1:0]     dispatch_t2_i,
    input  logic [DISPATCH_W-1:0]           dispatch_t2_rdy_i,
    input  logic [DISPATCH_W*CLS_W-1:0]     dispatch_class_i,
    input  logic [DISPATCH_W*PAYLOAD_W-1:0] dispatch_payload_i,
    output logic [DISPATCH_W-1:0]           dispatch_ack_o,
    input  logic [CDB_W-1:0]                cdb_valid_i,
    input  logic [CDB_W*TAG_W-1:0]          cdb_tag_i,
    input  logic [NUM_PORTS-1:0]            fu_ready_i,
    output logic [NUM_PORTS-1:0]            issue_valid_o,
    output logic [NUM_PORTS*PAYLOAD_W-1:0]  issue_payload_o,
    output logic [$clog2(RS_SIZE+1)-1:0]    free_cnt_o,
    output logic [$clog2(RS_SIZE+1)-1:0]    occupancy_o
);

    localparam int CNT_W = $clog2(RS_SIZE+1);
    localparam int IDX_W = $clog2(RS_SIZE);
    localparam logic [CNT_W-1:0] C_SIZE = CNT_W'(RS_SIZE);

    typedef struct packed {
        logic [TAG_W-1:0]     t1;
        logic                 t1_rdy;
        logic [TAG_W-1:0]     t2;
        logic                 t2_rdy;
        logic [CLS_W-1:0]     cls;
        logic [PAYLOAD_W-1:0] payload;
    } entry_t;

    entry_t               ent_q [RS_SIZE];
    entry_t               ent_d [RS_SIZE];
    logic [RS_SIZE-1:0]   valid_q, valid_d;
    logic [CNT_W-1:0]     occ_q, occ_d;

    logic [RS_SIZE-1:0]   ready;
    logic [RS_SIZE-1:0]   taken;
    logic [RS_SIZE-1:0]   pick_oh [NUM_PORTS];
    logic [NUM_PORTS-1:0] xfer;
    logic [RS_SIZE-1:0]   removed;
    logic [CNT_W-1:0]     slot;

    function automatic logic cdb_hit(input logic [TAG_W-1:0] tag);
        logic hit;
        hit = 1'b0;
        for (int c = 0; c < CDB_W; c++) begin
            hit = hit | (cdb_valid_i[c] & (cdb_tag_i[c*TAG_W +: TAG_W] == tag));
        end
        return hit;
    endfunction

    assign free_cnt_o  = C_SIZE - occ_q;
    assign occupancy_o = occ_q;
    assign xfer        = issue_valid_o & fu_ready_i;

    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            ready[i] = valid_q[i] & ent_q[i].t1_rdy & ent_q[i].t2_rdy;
        end
    end

    // Ports claim in ascending order; a stalled port still holds its pick.
    always_comb begin : p_select
        logic found;
        found           = 1'b0;
        taken           = '0;
        issue_valid_o   = '0;
        issue_payload_o = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            pick_oh[p] = '0;
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            found = 1'b0;
            for (int i = 0; i < RS_SIZE; i++) begin
                if (!found && ready[i] && !taken[i] &&
                    (ent_q[i].cls == PORT_CLASS[p*CLS_W +: CLS_W])) begin
                    found                                   = 1'b1;
                    taken[i]                                = 1'b1;
                    pick_oh[p][i]                           = 1'b1;
                    issue_valid_o[p]                        = 1'b1;
                    issue_payload_o[p*PAYLOAD_W +: PAYLOAD_W] = ent_q[i].payload;
                end
            end
        end
    end

    always_comb begin
        removed = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (xfer[p]) begin
                removed = removed | pick_oh[p];
            end
        end
    end

    // Free slots are counted before this cycle's issues retire.
    always_comb begin
        for (int k = 0; k < DISPATCH_W; k++) begin
            dispatch_ack_o[k] = dispatch_valid_i[k] & (CNT_W'(k) < free_cnt_o)
                                & ~flush_i & rst_ni;
        end
    end

    always_comb begin
        slot    = '0;
        valid_d = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            ent_d[i] = '0;
        end
        for (int i = 0; i < RS_SIZE; i++) begin
            if (valid_q[i] && !removed[i] && (slot < C_SIZE)) begin
                ent_d[slot[IDX_W-1:0]]   = ent_q[i];
                valid_d[slot[IDX_W-1:0]] = 1'b1;
                slot                     = slot + 1'b1;
            end
        end
        for (int k = 0; k < DISPATCH_W; k++) begin
            if (dispatch_ack_o[k] && (slot < C_SIZE)) begin
                ent_d[slot[IDX_W-1:0]].t1      = dispatch_t1_i[k*TAG_W +: TAG_W];
                ent_d[slot[IDX_W-1:0]].t1_rdy  = dispatch_t1_rdy_i[k];
                ent_d[slot[IDX_W-1:0]].t2      = dispatch_t2_i[k*TAG_W +: TAG_W];
                ent_d[slot[IDX_W-1:0]].t2_rdy  = dispatch_t2_rdy_i[k];
                ent_d[slot[IDX_W-1:0]].cls     = dispatch_class_i[k*CLS_W +: CLS_W];
                ent_d[slot[IDX_W-1:0]].payload = dispatch_payload_i[k*PAYLOAD_W +: PAYLOAD_W];
                valid_d[slot[IDX_W-1:0]]       = 1'b1;
                slot                           = slot + 1'b1;
            end
        end
        for (int i = 0; i < RS_SIZE; i++) begin
            if (valid_d[i]) begin
                ent_d[i].t1_rdy = ent_d[i].t1_rdy | cdb_hit(ent_d[i].t1);
                ent_d[i].t2_rdy = ent_d[i].t2_rdy | cdb_hit(ent_d[i].t2);
            end
        end
        occ_d = slot;
        if (flush_i) begin
            valid_d = '0;
            occ_d   = '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                ent_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            occ_q   <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
            for (int i = 0; i < RS_SIZE; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

    a_occ_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (occ_q <= C_SIZE) && (occ_d <= C_SIZE));
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $countones(xfer) <= int'(occ_q));

endmodule
`default_nettype wire

// File: tb/tb_rs_issue_queue.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rs_issue_queue : random stimulus against a queue-based reference model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_rs_issue_queue;

    localparam int RS_SIZE    = 16;
    localparam int DISPATCH_W = 3;
    localparam int CDB_W      = 3;
    localparam int NUM_PORTS  = 5;
    localparam int TAG_W      = 6;
    localparam int CLS_W      = 3;
    localparam int PAYLOAD_W  = 32;
    localparam int CNT_W      = $clog2(RS_SIZE+1);

    logic                            clk = 1'b0;
    logic                            rst_n;
    logic                            flush;
    logic [DISPATCH_W-1:0]           dv;
    logic [DISPATCH_W*TAG_W-1:0]     dt1;
    logic [DISPATCH_W-1:0]           dr1;
    logic [DISPATCH_W*TAG_W-1:0]     dt2;
    logic [DISPATCH_W-1:0]           dr2;
    logic [DISPATCH_W*CLS_W-1:0]     dcls;
    logic [DISPATCH_W*PAYLOAD_W-1:0] dpl;
    logic [DISPATCH_W-1:0]           ack;
    logic [CDB_W-1:0]                cv;
    logic [CDB_W*TAG_W-1:0]          ct;
    logic [NUM_PORTS-1:0]            fur;
    logic [NUM_PORTS-1:0]            iv;
    logic [NUM_PORTS*PAYLOAD_W-1:0]  ipl;
    logic [CNT_W-1:0]                free_cnt;
    logic [CNT_W-1:0]                occ;

    rs_issue_queue #(
        .RS_SIZE(RS_SIZE), .DISPATCH_W(DISPATCH_W), .CDB_W(CDB_W),
        .NUM_PORTS(NUM_PORTS), .TAG_W(TAG_W), .CLS_W(CLS_W),
        .PAYLOAD_W(PAYLOAD_W), .PORT_CLASS({3'd2, 3'd1, 3'd0, 3'd0, 3'd0})
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
        .dispatch_valid_i(dv), .dispatch_t1_i(dt1), .dispatch_t1_rdy_i(dr1),
        .dispatch_t2_i(dt2), .dispatch_t2_rdy_i(dr2), .dispatch_class_i(dcls),
        .dispatch_payload_i(dpl), .dispatch_ack_o(ack),
        .cdb_valid_i(cv), .cdb_tag_i(ct), .fu_ready_i(fur),
        .issue_valid_o(iv), .issue_payload_o(ipl),
        .free_cnt_o(free_cnt), .occupancy_o(occ)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned t1;
        bit          r1;
        int unsigned t2;
        bit          r2;
        int unsigned cls;
        logic [31:0] pl;
    } ent_t;

    ent_t q[$];
    int   port_cls[NUM_PORTS] = '{0, 0, 0, 1, 2};
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit woken(input int unsigned tag);
        bit h = 0;
        for (int c = 0; c < CDB_W; c++) begin
            if (cv[c] && (int'(ct[c*TAG_W +: TAG_W]) == tag)) h = 1;
        end
        return h;
    endfunction

    task automatic idle_inputs();
        flush = 0; dv = '0; dt1 = '0; dr1 = '0; dt2 = '0; dr2 = '0;
        dcls = '0; dpl = '0; cv = '0; ct = '0; fur = '0;
    endtask

    task automatic step(input int fu_pct, input int flush_pct, input int disp_max);
        int                    nd;
        int                    pick[NUM_PORTS];
        bit                    taken[RS_SIZE];
        bit                    gone[RS_SIZE];
        logic [DISPATCH_W-1:0] e_ack;
        logic [NUM_PORTS-1:0]  e_iv;
        int                    f;
        ent_t                  nq[$];
        ent_t                  e;

        @(negedge clk);
        nd = $urandom_range(0, disp_max);
        for (int k = 0; k < DISPATCH_W; k++) begin
            dv[k]                          = (k < nd);
            dt1[k*TAG_W +: TAG_W]          = TAG_W'($urandom_range(0, 7));
            dt2[k*TAG_W +: TAG_W]          = TAG_W'($urandom_range(0, 7));
            dr1[k]                         = ($urandom_range(0, 2) != 0);
            dr2[k]                         = ($urandom_range(0, 2) != 0);
            dcls[k*CLS_W +: CLS_W]         = CLS_W'($urandom_range(0, 2));
            dpl[k*PAYLOAD_W +: PAYLOAD_W]  = $urandom;
        end
        for (int c = 0; c < CDB_W; c++) begin
            cv[c]                 = ($urandom_range(0, 1) != 0);
            ct[c*TAG_W +: TAG_W]  = TAG_W'($urandom_range(0, 7));
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            fur[p] = ($urandom_range(0, 99) < fu_pct);
        end
        flush = ($urandom_range(0, 99) < flush_pct);
        #1;

        f = RS_SIZE - q.size();
        for (int k = 0; k < DISPATCH_W; k++) begin
            e_ack[k] = dv[k] && (k < f) && !flush;
        end
        for (int i = 0; i < RS_SIZE; i++) begin
            taken[i] = 0;
            gone[i]  = 0;
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            pick[p] = -1;
            for (int i = 0; i < q.size(); i++) begin
                if (pick[p] < 0 && !taken[i] && q[i].r1 && q[i].r2 && q[i].cls == port_cls[p]) begin
                    pick[p]  = i;
                    taken[i] = 1;
                end
            end
            e_iv[p] = (pick[p] >= 0);
        end

        chk("dispatch_ack", 64'(ack), 64'(e_ack));
        chk("issue_valid", 64'(iv), 64'(e_iv));
        chk("occupancy", 64'(occ), 64'(q.size()));
        chk("free_cnt", 64'(free_cnt), 64'(RS_SIZE - q.size()));
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (pick[p] >= 0) chk($sformatf("payload%0d", p), 64'(ipl[p*PAYLOAD_W +: PAYLOAD_W]), 64'(q[pick[p]].pl));
        end

        @(posedge clk);
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (pick[p] >= 0 && fur[p]) gone[pick[p]] = 1;
        end
        for (int i = 0; i < q.size(); i++) begin
            if (!gone[i]) nq.push_back(q[i]);
        end
        for (int k = 0; k < DISPATCH_W; k++) begin
            if (e_ack[k]) begin
                e.t1  = int'(dt1[k*TAG_W +: TAG_W]);
                e.t2  = int'(dt2[k*TAG_W +: TAG_W]);
                e.r1  = dr1[k];
                e.r2  = dr2[k];
                e.cls = int'(dcls[k*CLS_W +: CLS_W]);
                e.pl  = dpl[k*PAYLOAD_W +: PAYLOAD_W];
                nq.push_back(e);
            end
        end
        for (int i = 0; i < nq.size(); i++) begin
            if (woken(nq[i].t1)) nq[i].r1 = 1;
            if (woken(nq[i].t2)) nq[i].r2 = 1;
        end
        if (flush) nq.delete();
        q = nq;
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_occ"}, 64'(occ), 64'd0);
        chk({tag, "_free"}, 64'(free_cnt), 64'(RS_SIZE));
        chk({tag, "_ivalid"}, 64'(iv), 64'd0);
        chk({tag, "_ack"}, 64'(ack), 64'd0);
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        dv    = '1;
        #2;
        check_cleared("reset");
        @(negedge clk);
        dv    = '0;
        rst_n = 1'b1;

        for (int n = 0; n < 300; n++) step(70, 2, 3);
        for (int n = 0; n < 40; n++)  step(0, 0, 3);
        for (int n = 0; n < 60; n++)  step(25, 0, 3);
        for (int n = 0; n < 20; n++)  step(0, 0, 3);

        // Asynchronous reset well away from any clock edge, with a full queue.
        #3;
        rst_n = 1'b0;
        #1;
        check_cleared("async_reset");
        q.delete();
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 300; n++) step(50, 3, 3);
        for (int n = 0; n < 200; n++) step(90, 1, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
